// File: rtl/diffio_pattern_checker_sm.sv
// Receive side of the differential IO checker: regenerates the transmit LFSR sequence
// in lockstep with the pattern generator and scores every bit returned by the channel.
module diffio_pattern_checker_sm #(
   parameter int unsigned NUM_BITS_TO_CHECK = 1000,
   parameter logic [31:0] SEED              = 32'hABCDEF01,
   parameter int unsigned ALIGN_TICKS       = 0,
   parameter int unsigned ERR_CNT_WIDTH     = 16
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     CLK_EN,
   input  logic                     START,
   input  logic                     RX_BIT,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     PASS,
   output logic                     ERR_SEEN,
   output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT,
   output logic [31:0]              FIRST_ERR_IDX
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ALIGN  = 3'd1,
      ST_HOLD   = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam logic [31:0]              LAST_BIT   = 32'(NUM_BITS_TO_CHECK - 1);
   localparam logic [7:0]               ALIGN_LAST = (ALIGN_TICKS > 0) ? 8'(ALIGN_TICKS - 1) : 8'd0;
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = {ERR_CNT_WIDTH{1'b1}};
   localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE    = ERR_CNT_WIDTH'(1'b1);
   localparam state_t                   START_DEST = (ALIGN_TICKS > 0) ? ST_ALIGN : ST_HOLD;

   // Same polynomial as the generator, so both ends walk the identical sequence.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {v[30:0], v[30] ^ v[27]};
   endfunction

   state_t                   r_state, w_state_nxt;
   logic                     r_rx_meta, r_rx_sync;
   logic [31:0]              r_lfsr, w_lfsr_nxt;
   logic [31:0]              r_bit_cnt, w_bit_cnt_nxt;
   logic [31:0]              r_first_idx, w_first_idx_nxt;
   logic [7:0]               r_align_cnt, w_align_cnt_nxt;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt, w_err_cnt_nxt;
   logic                     r_err_seen, w_err_seen_nxt;
   logic                     r_pass, w_pass_nxt;
   logic                     r_busy, w_busy_nxt;
   logic                     r_done, w_done_nxt;
   logic                     w_mismatch;

   // RX_BIT is asynchronous; resynchronise on every CLK so it settles between ticks.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rx_meta <= 1'b0;
         r_rx_sync <= 1'b0;
      end else begin
         r_rx_meta <= RX_BIT;
         r_rx_sync <= r_rx_meta;
      end
   end

   // Next-state, datapath and output decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_lfsr_nxt      = r_lfsr;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_align_cnt_nxt = r_align_cnt;
      w_err_cnt_nxt   = r_err_cnt;
      w_err_seen_nxt  = r_err_seen;
      w_first_idx_nxt = r_first_idx;
      w_pass_nxt      = r_pass;
      w_mismatch      = r_rx_sync ^ r_lfsr[31];
      case (r_state)
         ST_IDLE: begin
            if (CLK_EN && START) begin
               w_state_nxt     = START_DEST;
               w_err_cnt_nxt   = '0;
               w_err_seen_nxt  = 1'b0;
               w_pass_nxt      = 1'b0;
               w_first_idx_nxt = 32'd0;
               w_bit_cnt_nxt   = 32'd0;
               w_align_cnt_nxt = 8'd0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ALIGN: begin
            if (CLK_EN) begin
               w_align_cnt_nxt = r_align_cnt + 8'd1;
               if (r_align_cnt == ALIGN_LAST) begin
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_state_nxt = ST_ALIGN;
               end
            end else begin
               w_state_nxt = ST_ALIGN;
            end
         end
         ST_HOLD: begin
            if (CLK_EN) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_SAMPLE: begin
            if (CLK_EN) begin
               if (w_mismatch) begin
                  w_err_cnt_nxt = (r_err_cnt == ERR_MAX) ? ERR_MAX : (r_err_cnt + ERR_ONE);
                  if (!r_err_seen) begin
                     w_err_seen_nxt  = 1'b1;
                     w_first_idx_nxt = r_bit_cnt;
                  end else begin
                     w_err_seen_nxt  = r_err_seen;
                  end
               end else begin
                  w_err_cnt_nxt = r_err_cnt;
               end
               // The last compare lands in the same tick as the verdict, so fold it in directly.
               if (r_bit_cnt == LAST_BIT) begin
                  w_lfsr_nxt    = SEED;
                  w_bit_cnt_nxt = 32'd0;
                  w_state_nxt   = ST_DONE;
                  w_pass_nxt    = !r_err_seen && !w_mismatch;
               end else begin
                  w_lfsr_nxt    = lfsr_step(r_lfsr);
                  w_bit_cnt_nxt = r_bit_cnt + 32'd1;
                  w_state_nxt   = ST_HOLD;
               end
            end else begin
               w_state_nxt = ST_SAMPLE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_busy_nxt = (w_state_nxt == ST_ALIGN) || (w_state_nxt == ST_HOLD) ||
                   (w_state_nxt == ST_SAMPLE);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   // State and result registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state     <= ST_IDLE;
         r_lfsr      <= SEED;
         r_bit_cnt   <= 32'd0;
         r_align_cnt <= 8'd0;
         r_err_cnt   <= '0;
         r_err_seen  <= 1'b0;
         r_first_idx <= 32'd0;
         r_pass      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_lfsr      <= w_lfsr_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_align_cnt <= w_align_cnt_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
         r_err_seen  <= w_err_seen_nxt;
         r_first_idx <= w_first_idx_nxt;
         r_pass      <= w_pass_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign BUSY          = r_busy;
   assign DONE          = r_done;
   assign PASS          = r_pass;
   assign ERR_SEEN      = r_err_seen;
   assign ERR_COUNT     = r_err_cnt;
   assign FIRST_ERR_IDX = r_first_idx;

endmodule
